// File: rtl/debug_defs_pkg.sv
// Shared definitions for the debug command unit: client/host opcodes,
// controller state encoding, frame length and a PC byte selector.
package debug_defs_pkg;

  // Client -> block opcodes
  localparam logic [7:0] OP_PING    = 8'h03;
  localparam logic [7:0] OP_PAUSE   = 8'h04;
  localparam logic [7:0] OP_RESUME  = 8'h05;
  localparam logic [7:0] OP_NEXT    = 8'h06;
  localparam logic [7:0] OP_PROGRAM = 8'h07;
  // Block -> client opcodes
  localparam logic [7:0] OP_OK      = 8'h02;
  localparam logic [7:0] OP_SIGNAL  = 8'h01;

  // OP_SIGNAL frame: opcode byte followed by four PC bytes
  localparam int unsigned FRAME_BYTES = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BP_COLLECT,
    ST_PROG_COLLECT,
    ST_PROG_WRITE,
    ST_STEP_WAIT,
    ST_TX_OP,
    ST_TX_PC
  } dbg_state_e;

  // Little-endian byte select of a 32-bit PC
  function automatic logic [7:0] pc_byte(input logic [31:0] pc, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = pc[7:0];
      2'd1:    b = pc[15:8];
      2'd2:    b = pc[23:16];
      default: b = pc[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dbg_byte_packer.sv
// Assembles four received bytes (first byte -> bits [7:0]) into a 32-bit word.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   i_clear     restart assembly at byte 0
//   i_valid     i_byte is a new byte
//   i_byte      received byte
//   o_word      assembled word, valid while o_done is high
//   o_done      high in the cycle the fourth byte is presented
module dbg_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_done
);

  logic [31:0] r_shift;
  logic [1:0]  r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_valid) begin
      r_shift <= {i_byte, r_shift[31:8]};
      r_count <= r_count + 2'd1;
    end
  end

  // Word is presented combinationally with the 4th byte so the caller can
  // act on it in the same cycle; the count wraps to 0 for the next word.
  assign o_done = i_valid && !i_clear && (r_count == 2'd3);
  assign o_word = {i_byte, r_shift[31:8]};

endmodule

// File: rtl/debug_cmd_ctrl.sv
// Debug-unit command sequencer between the UART byte stream and the CPU core.
// Decodes client opcodes, pauses/resumes/single-steps the CPU, arms a
// breakpoint, streams program words into instruction memory and reports the
// PC in OP_SIGNAL frames.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   rx_data, rx_valid      received byte + 1-cycle strobe
//   tx_data, tx_valid      byte to send, held until tx_ready
//   tx_ready               transmitter accepts when tx_valid & tx_ready
//   cpu_pc                 PC of the instruction about to execute
//   cpu_pause, cpu_step    CPU stall level, single-step pulse
//   prog_active            CPU held in reset, imem owned by this block
//   prog_we/addr/data      imem word write port
module debug_cmd_ctrl
  import debug_defs_pkg::*;
#(
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned TIMEOUT_CYCLES = 40000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [PC_WIDTH-1:0]   cpu_pc,
  output logic                  cpu_pause,
  output logic                  cpu_step,
  output logic                  prog_active,
  output logic                  prog_we,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic [31:0]           prog_data
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  dbg_state_e            r_state,       w_state_nxt;
  logic                  r_pause,       w_pause_nxt;
  logic                  r_bp_valid,    w_bp_valid_nxt;
  logic [PC_WIDTH-1:0]   r_bp_addr,     w_bp_addr_nxt;
  logic                  r_bp_pend,     w_bp_pend_nxt;
  logic                  r_prog_active, w_prog_active_nxt;
  logic [ADDR_WIDTH-1:0] r_prog_addr,   w_prog_addr_nxt;
  logic [31:0]           r_prog_data,   w_prog_data_nxt;
  logic [7:0]            r_tx_op,       w_tx_op_nxt;
  logic                  r_tx_pc,       w_tx_pc_nxt;
  logic [31:0]           r_pc,          w_pc_nxt;
  logic [1:0]            r_byte_idx,    w_byte_idx_nxt;
  logic                  r_pend_valid,  w_pend_valid_nxt;
  logic [7:0]            r_pend_data,   w_pend_data_nxt;
  logic [CNT_W-1:0]      r_cnt,         w_cnt_nxt;
  logic                  r_step_ph,     w_step_ph_nxt;

  logic                  w_bp_hit;
  logic                  w_bp_req;
  logic                  w_op_valid;
  logic [7:0]            w_op;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [31:0]           w_pc32;
  logic                  w_pk_valid;
  logic                  w_pk_clear;
  logic [31:0]           w_pk_word;
  logic                  w_pk_done;

  dbg_byte_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_pk_clear),
    .i_valid (w_pk_valid),
    .i_byte  (rx_data),
    .o_word  (w_pk_word),
    .o_done  (w_pk_done)
  );

  assign w_pk_clear = (r_state == ST_IDLE);
  assign w_pk_valid = rx_valid && ((r_state == ST_BP_COLLECT) ||
                                   (r_state == ST_PROG_COLLECT) ||
                                   (r_state == ST_PROG_WRITE));

  // Breakpoint stalls the CPU combinationally so the matched instruction never executes.
  assign w_bp_hit  = !r_pause && r_bp_valid && (cpu_pc == r_bp_addr);
  assign w_bp_req  = w_bp_hit || r_bp_pend;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_pc32    = 32'(cpu_pc);

  assign cpu_pause   = r_pause || w_bp_hit;
  assign cpu_step    = (r_state == ST_STEP_WAIT) && !r_step_ph && r_pause;
  assign tx_valid    = (r_state == ST_TX_OP) || (r_state == ST_TX_PC);
  assign prog_active = r_prog_active;
  assign prog_we     = (r_state == ST_PROG_WRITE);
  assign prog_addr   = r_prog_addr;
  assign prog_data   = r_prog_data;

  always_comb begin
    tx_data = '0;
    if (r_state == ST_TX_OP)      tx_data = r_tx_op;
    else if (r_state == ST_TX_PC) tx_data = pc_byte(r_pc, r_byte_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pause       <= 1'b0;
      r_bp_valid    <= 1'b0;
      r_bp_addr     <= '0;
      r_bp_pend     <= 1'b0;
      r_prog_active <= 1'b0;
      r_prog_addr   <= '0;
      r_prog_data   <= '0;
      r_tx_op       <= '0;
      r_tx_pc       <= 1'b0;
      r_pc          <= '0;
      r_byte_idx    <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_data   <= '0;
      r_cnt         <= '0;
      r_step_ph     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pause       <= w_pause_nxt;
      r_bp_valid    <= w_bp_valid_nxt;
      r_bp_addr     <= w_bp_addr_nxt;
      r_bp_pend     <= w_bp_pend_nxt;
      r_prog_active <= w_prog_active_nxt;
      r_prog_addr   <= w_prog_addr_nxt;
      r_prog_data   <= w_prog_data_nxt;
      r_tx_op       <= w_tx_op_nxt;
      r_tx_pc       <= w_tx_pc_nxt;
      r_pc          <= w_pc_nxt;
      r_byte_idx    <= w_byte_idx_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_data   <= w_pend_data_nxt;
      r_cnt         <= w_cnt_nxt;
      r_step_ph     <= w_step_ph_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pause_nxt       = r_pause;
    w_bp_valid_nxt    = r_bp_valid;
    w_bp_addr_nxt     = r_bp_addr;
    w_bp_pend_nxt     = r_bp_pend || w_bp_hit;
    w_prog_active_nxt = r_prog_active;
    w_prog_addr_nxt   = r_prog_addr;
    w_prog_data_nxt   = r_prog_data;
    w_tx_op_nxt       = r_tx_op;
    w_tx_pc_nxt       = r_tx_pc;
    w_pc_nxt          = r_pc;
    w_byte_idx_nxt    = r_byte_idx;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_data_nxt   = r_pend_data;
    w_cnt_nxt         = r_cnt;
    w_step_ph_nxt     = r_step_ph;
    w_op_valid        = 1'b0;
    w_op              = rx_data;

    if (w_bp_hit) begin
      w_pause_nxt    = 1'b1;
      w_bp_valid_nxt = 1'b0;
    end

    unique case (r_state)
      ST_IDLE: begin
        // Priority: breakpoint frame, then the parked byte, then a fresh byte.
        // Anything not consumed this cycle is parked (newest wins).
        if (w_bp_req) begin
          w_bp_pend_nxt = 1'b0;
          w_tx_op_nxt   = OP_SIGNAL;
          w_tx_pc_nxt   = 1'b1;
          w_state_nxt   = ST_TX_OP;
          if (rx_valid) begin
            w_pend_valid_nxt = 1'b1;
            w_pend_data_nxt  = rx_data;
          end
        end else if (r_pend_valid) begin
          w_op_valid       = 1'b1;
          w_op             = r_pend_data;
          w_pend_valid_nxt = rx_valid;
          if (rx_valid) w_pend_data_nxt = rx_data;
        end else if (rx_valid) begin
          w_op_valid = 1'b1;
        end

        if (w_op_valid) begin
          case (w_op)
            OP_PING: begin
              w_tx_op_nxt = OP_OK;
              w_tx_pc_nxt = 1'b0;
              w_state_nxt = ST_TX_OP;
            end
            OP_PAUSE: begin
              w_pause_nxt = 1'b1;
              w_tx_op_nxt = OP_SIGNAL;
              w_tx_pc_nxt = 1'b1;
              w_state_nxt = ST_TX_OP;
            end
            OP_RESUME:  w_state_nxt = ST_BP_COLLECT;
            OP_NEXT: begin
              w_step_ph_nxt = 1'b0;
              w_state_nxt   = ST_STEP_WAIT;
            end
            OP_PROGRAM: begin
              w_prog_active_nxt = 1'b1;
              w_prog_addr_nxt   = '0;
              w_cnt_nxt         = '0;
              w_state_nxt       = ST_PROG_COLLECT;
            end
            default: ;
          endcase
        end
      end

      ST_BP_COLLECT: begin
        if (w_pk_done) begin
          w_bp_addr_nxt  = w_pk_word[PC_WIDTH-1:0];
          w_bp_valid_nxt = 1'b1;
          w_pause_nxt    = 1'b0;
          w_state_nxt    = ST_IDLE;
        end
      end

      ST_PROG_COLLECT: begin
        w_cnt_nxt = rx_valid ? '0 : w_cnt_inc;
        if (w_pk_done) begin
          w_prog_data_nxt = w_pk_word;
          w_state_nxt     = ST_PROG_WRITE;
        end else if (!rx_valid && (w_cnt_inc >= CNT_W'(TIMEOUT_CYCLES))) begin
          // Any partial word left in the packer is dropped by the IDLE clear.
          w_prog_active_nxt = 1'b0;
          w_pause_nxt       = 1'b0;
          w_tx_op_nxt       = OP_OK;
          w_tx_pc_nxt       = 1'b0;
          w_state_nxt       = ST_TX_OP;
        end
      end

      ST_PROG_WRITE: begin
        w_cnt_nxt       = rx_valid ? '0 : w_cnt_inc;
        w_prog_addr_nxt = r_prog_addr + 1'b1;
        w_state_nxt     = ST_PROG_COLLECT;
      end

      ST_STEP_WAIT: begin
        if (rx_valid) begin
          w_pend_valid_nxt = 1'b1;
          w_pend_data_nxt  = rx_data;
        end
        if (!r_step_ph) begin
          if (!r_pause) begin
            // Running CPU: behave as PAUSE. A same-cycle breakpoint hit would
            // report the same PC, so it does not queue a second frame.
            w_pause_nxt   = 1'b1;
            w_bp_pend_nxt = r_bp_pend;
            w_tx_op_nxt   = OP_SIGNAL;
            w_tx_pc_nxt   = 1'b1;
            w_state_nxt   = ST_TX_OP;
          end else begin
            w_step_ph_nxt = 1'b1;
          end
        end else begin
          w_tx_op_nxt = OP_SIGNAL;
          w_tx_pc_nxt = 1'b1;
          w_state_nxt = ST_TX_OP;
        end
      end

      ST_TX_OP: begin
        if (rx_valid) begin
          w_pend_valid_nxt = 1'b1;
          w_pend_data_nxt  = rx_data;
        end
        if (tx_ready) begin
          if (r_tx_pc) begin
            // CPU is already stalled here, so the PC is stable for the frame.
            w_pc_nxt       = w_pc32;
            w_byte_idx_nxt = '0;
            w_state_nxt    = ST_TX_PC;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      ST_TX_PC: begin
        if (rx_valid) begin
          w_pend_valid_nxt = 1'b1;
          w_pend_data_nxt  = rx_data;
        end
        if (tx_ready) begin
          if (r_byte_idx == 2'(FRAME_BYTES - 2)) w_state_nxt = ST_IDLE;
          else w_byte_idx_nxt = r_byte_idx + 2'd1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_debug_cmd_ctrl.sv
// Directed bench for debug_cmd_ctrl with a small CPU PC model and monitors
// for transmitted bytes, step pulses and imem writes.
module tb_debug_cmd_ctrl;

  localparam int unsigned T_OUT = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] cpu_pc = 32'h0;
  logic        cpu_pause;
  logic        cpu_step;
  logic        prog_active;
  logic        prog_we;
  logic [13:0] prog_addr;
  logic [31:0] prog_data;

  debug_cmd_ctrl #(
    .PC_WIDTH       (32),
    .ADDR_WIDTH     (14),
    .TIMEOUT_CYCLES (T_OUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .cpu_pc      (cpu_pc),
    .cpu_pause   (cpu_pause),
    .cpu_step    (cpu_step),
    .prog_active (prog_active),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitors
  logic [7:0]  txq[$];
  logic [13:0] we_addr[$];
  logic [31:0] we_data[$];
  int unsigned step_cnt = 0;

  always @(posedge clk) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (cpu_step) step_cnt++;
    if (prog_we) begin
      we_addr.push_back(prog_addr);
      we_data.push_back(prog_data);
    end
  end

  // CPU model: PC advances by 4 per executed instruction
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = 32'h0;
  logic        model_run = 1'b0;

  always @(posedge clk) begin
    if (pc_load) cpu_pc <= pc_load_val;
    else if (model_run && (!cpu_pause || cpu_step)) cpu_pc <= cpu_pc + 32'd4;
  end

  function automatic logic [7:0] q_at(input int i);
    if (i < txq.size()) return txq[i];
    return 8'hEE;
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    @(negedge clk);
    pc_load_val = v;
    pc_load     = 1'b1;
    @(negedge clk);
    pc_load     = 1'b0;
  endtask

  task automatic wait_txq(input int n, input int unsigned bound, input string tag);
    int unsigned k = 0;
    while (txq.size() < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (txq.size() < n) check({tag, "_timeout"}, 32'(txq.size()), 32'(n));
  endtask

  task automatic check_frame(input string tag, input int base, input logic [31:0] pc);
    check({tag, "_b0"}, 32'(q_at(base)),     32'h01);
    check({tag, "_b1"}, 32'(q_at(base + 1)), 32'(pc[7:0]));
    check({tag, "_b2"}, 32'(q_at(base + 2)), 32'(pc[15:8]));
    check({tag, "_b3"}, 32'(q_at(base + 3)), 32'(pc[23:16]));
    check({tag, "_b4"}, 32'(q_at(base + 4)), 32'(pc[31:24]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int base;
    int wbase;
    int unsigned s0;
    int unsigned n;

    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    tick(3);
    check("rst_pause",   32'(cpu_pause),   32'h0);
    check("rst_step",    32'(cpu_step),    32'h0);
    check("rst_txvalid", 32'(tx_valid),    32'h0);
    check("rst_txdata",  32'(tx_data),     32'h0);
    check("rst_pactive", 32'(prog_active), 32'h0);
    check("rst_pwe",     32'(prog_we),     32'h0);
    check("rst_paddr",   32'(prog_addr),   32'h0);
    check("rst_pdata",   prog_data,        32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // PING -> single 02, CPU keeps running
    base = txq.size();
    send_byte(8'h03);
    wait_txq(base + 1, 20, "ping");
    tick(10);
    check("ping_count", 32'(txq.size() - base), 32'd1);
    check("ping_byte",  32'(q_at(base)),        32'h02);
    check("ping_pause", 32'(cpu_pause),         32'h0);

    // PAUSE at 0x20, tx stalled mid-frame; a PING arriving meanwhile is parked
    set_pc(32'h20);
    base = txq.size();
    send_byte(8'h04);
    check("pause_latency", 32'(cpu_pause), 32'h1);
    wait_txq(base + 2, 20, "pause_head");
    tx_ready = 1'b0;
    send_byte(8'h03);
    tick(8);
    check("stall_count", 32'(txq.size() - base), 32'd2);
    check("stall_valid", 32'(tx_valid),          32'h1);
    tx_ready = 1'b1;
    wait_txq(base + 6, 40, "pause");
    tick(10);
    check("pause_count", 32'(txq.size() - base), 32'd6);
    check_frame("pause", base, 32'h20);
    check("pending_ping", 32'(q_at(base + 5)), 32'h02);
    check("pause_held",   32'(cpu_pause),      32'h1);

    // NEXT while paused at 0x04 -> one step, report 0x08
    set_pc(32'h04);
    model_run = 1'b1;
    s0   = step_cnt;
    base = txq.size();
    send_byte(8'h06);
    wait_txq(base + 5, 40, "next");
    tick(10);
    check("next_steps", 32'(step_cnt - s0),      32'd1);
    check("next_count", 32'(txq.size() - base), 32'd5);
    check_frame("next", base, 32'h08);
    check("next_pc",    cpu_pc,                  32'h08);

    // RESUME to breakpoint 0x0C from pc 0
    set_pc(32'h00);
    base = txq.size();
    send_byte(8'h05);
    send_byte(8'h0C);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check("resume_run", 32'(cpu_pause), 32'h0);
    n = 0;
    while (!cpu_pause && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_pause",    32'(cpu_pause), 32'h1);
    check("bp_pc_match", cpu_pc,         32'h0C);
    tick(3);
    check("bp_pc_hold",  cpu_pc,         32'h0C);
    wait_txq(base + 5, 40, "bp");
    tick(10);
    check("bp_count", 32'(txq.size() - base), 32'd5);
    check_frame("bp", base, 32'h0C);

    // PROGRAM two words plus a stray byte, then idle timeout
    model_run = 1'b0;
    base  = txq.size();
    wbase = we_addr.size();
    send_byte(8'h07);
    check("prog_active_on", 32'(prog_active), 32'h1);
    repeat (4) send_byte(8'h01);
    repeat (4) send_byte(8'h02);
    send_byte(8'hAA);
    n = 0;
    while (prog_active && n < T_OUT + 50) begin
      @(negedge clk);
      n++;
    end
    check("prog_timeout_cycles", n, T_OUT);
    check("prog_active_off", 32'(prog_active), 32'h0);
    check("prog_we_count", 32'(we_addr.size() - wbase), 32'd2);
    if (we_addr.size() >= wbase + 2) begin
      check("prog_addr0", 32'(we_addr[wbase]),     32'h0);
      check("prog_data0", we_data[wbase],          32'h01010101);
      check("prog_addr1", 32'(we_addr[wbase + 1]), 32'h1);
      check("prog_data1", we_data[wbase + 1],      32'h02020202);
    end
    wait_txq(base + 1, 20, "prog_ok");
    tick(10);
    check("prog_tx_count", 32'(txq.size() - base), 32'd1);
    check("prog_tx_ok",    32'(q_at(base)),        32'h02);
    check("prog_unpause",  32'(cpu_pause),         32'h0);

    // Reset in the middle of a PROGRAM word
    base  = txq.size();
    wbase = we_addr.size();
    send_byte(8'h07);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_pactive", 32'(prog_active), 32'h0);
    check("mrst_pause",   32'(cpu_pause),   32'h0);
    check("mrst_txvalid", 32'(tx_valid),    32'h0);
    check("mrst_paddr",   32'(prog_addr),   32'h0);
    check("mrst_pdata",   prog_data,        32'h0);
    tick(2);
    rst_n = 1'b1;
    send_byte(8'h33);
    send_byte(8'h44);
    tick(5);
    check("mrst_no_write", 32'(we_addr.size() - wbase), 32'd0);
    check("mrst_no_tx",    32'(txq.size() - base),      32'd0);
    check("mrst_pwe",      32'(prog_we),                32'h0);
    base = txq.size();
    send_byte(8'h03);
    wait_txq(base + 1, 20, "mrst_ping");
    tick(5);
    check("mrst_ping_count", 32'(txq.size() - base), 32'd1);
    check("mrst_ping_byte",  32'(q_at(base)),        32'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
